balsa_binfunc_arbiter: RTL and testbench

// - Clocked round-robin arbiter/sequencer sharing one two-operand W-bit binary-function unit (AND datapath) among N_REQ requesters.
// - Requester side and FU side are four-phase return-to-zero bundled-data channels (r/a/d), matching the buffer/fetch channel style.
// - Sits between client buffers and the single function unit; serialises operand fetch, issue, result return.

---
 rtl/balsa_arb_pkg.sv | 29 ++
 rtl/balsa_rr_pick.sv | 32 +++
 rtl/balsa_binfunc_arbiter.sv | 155 +++++++++++++++
 tb/tb_balsa_binfunc_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/balsa_arb_pkg.sv
// balsa_arb_pkg: shared state encoding, function-unit op codes and a width
// helper for balsa_binfunc_arbiter and its round-robin picker.
package balsa_arb_pkg;

  // Arbiter sequencing states: pick -> FU request -> FU return-to-zero -> client ack
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    FU_RTZ = 2'd2,
    ACK    = 2'd3
  } arb_state_e;

  // Function-unit operation codes (carried on fu_op when op select is built in)
  localparam logic [1:0] OP_AND    = 2'd0;
  localparam logic [1:0] OP_OR     = 2'd1;
  localparam logic [1:0] OP_XOR    = 2'd2;
  localparam logic [1:0] OP_PASS_A = 2'd3;

  // Bits needed to hold an index in 0..n-1 (n >= 2)
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/balsa_rr_pick.sv
// balsa_rr_pick: combinational round-robin priority picker. Returns the first
// set request bit found searching upward from i_ptr, wrapping past N_REQ-1.
module balsa_rr_pick
  import balsa_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  logic [IDX_W-1:0] w_cand;

  // Scan offsets from farthest to nearest so the nearest set bit wins last
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    o_valid = 1'b0;
    o_idx   = '0;
    w_cand  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      w_cand = IDX_W'((int'(i_ptr) + i) % N_REQ);
      if (i_req[w_cand]) begin
        o_valid = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/balsa_binfunc_arbiter.sv
// balsa_binfunc_arbiter: round-robin sequencer sharing one two-operand
// function unit among N_REQ four-phase bundled-data requesters.
// Optional build macro BINFUNC_ARB_OPSEL_EN adds per-requester op select
// (req_op) forwarded to the function unit on fu_op.
module balsa_binfunc_arbiter
  import balsa_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         initialise_n,
  input  logic [N_REQ-1:0]             req_r,
  output logic [N_REQ-1:0]             req_a,
  input  logic [N_REQ*WIDTH-1:0]       req_ad,
  input  logic [N_REQ*WIDTH-1:0]       req_bd,
`ifdef BINFUNC_ARB_OPSEL_EN
  input  logic [N_REQ*2-1:0]           req_op,
  output logic [1:0]                   fu_op,
`endif
  output logic [WIDTH-1:0]             res_d,
  output logic                         fu_r,
  input  logic                         fu_a,
  output logic [WIDTH-1:0]             fu_ad,
  output logic [WIDTH-1:0]             fu_bd,
  input  logic [WIDTH-1:0]             fu_od,
  output logic                         busy,
  output logic [clog2(N_REQ)-1:0]      grant_idx
);

  localparam int IDX_W = clog2(N_REQ);

  arb_state_e       r_state;
  arb_state_e       w_state_next;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] r_grant_idx;
  logic [IDX_W-1:0] w_ptr_next;
  logic [WIDTH-1:0] r_fu_ad;
  logic [WIDTH-1:0] r_fu_bd;
  logic [WIDTH-1:0] r_res_d;
  logic             w_pick_valid;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_latch_ops;
  logic             w_capture_res;
  logic             w_advance_ptr;
  logic [WIDTH-1:0] w_ad_slice [N_REQ];
  logic [WIDTH-1:0] w_bd_slice [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_slice
    assign w_ad_slice[k] = req_ad[k*WIDTH +: WIDTH];
    assign w_bd_slice[k] = req_bd[k*WIDTH +: WIDTH];
  end

  balsa_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req   (req_r),
    .i_ptr   (r_rr_ptr),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  // Winner moves to lowest priority: pointer goes one past it, wrapping at N_REQ
  assign w_ptr_next = (r_grant_idx == IDX_W'(N_REQ - 1)) ? '0 : r_grant_idx + 1'b1;

  // State register
  always_ff @(posedge clk or negedge initialise_n) begin
    // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
    if (!initialise_n) r_state <= IDLE;
    else               r_state <= w_state_next;
  end

  // Next-state decode and datapath enables for the four-phase handshakes
  always_comb begin
    w_state_next  = r_state;
    w_latch_ops   = 1'b0;
    w_capture_res = 1'b0;
    w_advance_ptr = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_latch_ops  = 1'b1;
          w_state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (fu_a) begin
          w_capture_res = 1'b1;
          w_state_next  = FU_RTZ;
        end
      end
      FU_RTZ: begin
        if (!fu_a) w_state_next = ACK;
      end
      ACK: begin
        if (!req_r[r_grant_idx]) begin
          w_advance_ptr = 1'b1;
          w_state_next  = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Grant/operand latch in IDLE, result capture on FU ack, pointer rotation on release
  always_ff @(posedge clk or negedge initialise_n) begin
    if (!initialise_n) begin
      r_grant_idx <= '0;
      r_fu_ad     <= '0;
      r_fu_bd     <= '0;
      r_res_d     <= '0;
      r_rr_ptr    <= '0;
    end else begin
      if (w_latch_ops) begin
        r_grant_idx <= w_pick_idx;
        r_fu_ad     <= w_ad_slice[w_pick_idx];
        r_fu_bd     <= w_bd_slice[w_pick_idx];
      end
      if (w_capture_res) r_res_d  <= fu_od;
      if (w_advance_ptr) r_rr_ptr <= w_ptr_next;
    end
  end

`ifdef BINFUNC_ARB_OPSEL_EN
  logic [1:0] r_fu_op;
  logic [1:0] w_op_slice [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_op_slice
    assign w_op_slice[k] = req_op[k*2 +: 2];
  end

  // Op code travels with the operands, latched at the same IDLE pick
  always_ff @(posedge clk or negedge initialise_n) begin
    if (!initialise_n)    r_fu_op <= OP_AND;
    else if (w_latch_ops) r_fu_op <= w_op_slice[w_pick_idx];
  end

  assign fu_op = r_fu_op;
`endif

  // Client ack is only ever the single granted bit, and only in ACK
  always_comb begin
    req_a = '0;
    if (r_state == ACK) req_a[r_grant_idx] = 1'b1;
  end

  assign fu_r      = (r_state == ISSUE);
  assign busy      = (r_state != IDLE);
  assign fu_ad     = r_fu_ad;
  assign fu_bd     = r_fu_bd;
  assign res_d     = r_res_d;
  assign grant_idx = r_grant_idx;

endmodule

// File: tb/tb_balsa_binfunc_arbiter.sv
// tb_balsa_binfunc_arbiter: self-checking bench for balsa_binfunc_arbiter.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_balsa_binfunc_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk;
  logic           initialise_n;
  logic [N-1:0]   req_r;
  logic [N-1:0]   req_a;
  logic [N*W-1:0] req_ad;
  logic [N*W-1:0] req_bd;
  logic [W-1:0]   res_d;
  logic           fu_r;
  logic           fu_a;
  logic [W-1:0]   fu_ad;
  logic [W-1:0]   fu_bd;
  logic [W-1:0]   fu_od;
  logic           busy;
  logic [1:0]     grant_idx;
  logic [1:0]     w_fu_op;
`ifdef BINFUNC_ARB_OPSEL_EN
  logic [N*2-1:0] req_op;
  logic [1:0]     fu_op;
  assign w_fu_op = fu_op;
`else
  assign w_fu_op = 2'd0;
`endif

  balsa_binfunc_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk          (clk),
    .initialise_n (initialise_n),
    .req_r        (req_r),
    .req_a        (req_a),
    .req_ad       (req_ad),
    .req_bd       (req_bd),
`ifdef BINFUNC_ARB_OPSEL_EN
    .req_op       (req_op),
    .fu_op        (fu_op),
`endif
    .res_d        (res_d),
    .fu_r         (fu_r),
    .fu_a         (fu_a),
    .fu_ad        (fu_ad),
    .fu_bd        (fu_bd),
    .fu_od        (fu_od),
    .busy         (busy),
    .grant_idx    (grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int viol     = 0;
  int fu_delay = 1;
  int fu_cnt   = 0;
  int m_ptr    = 0;
  logic [W-1:0] exp_a  [N];
  logic [W-1:0] exp_b  [N];
  logic [1:0]   exp_op [N];

  typedef struct {
    int         idx;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
  } vec_t;
  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Function the FU performs for an op code (AND only in the default build)
  function automatic logic [W-1:0] ref_fn(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return a;
    endcase
  endfunction

  // Next winner: first pending requester at or after the pointer, with wrap
  function automatic int ref_pick(input logic [N-1:0] pend, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (pend[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic set_req(input int k, input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    exp_a[k]  = a;
    exp_b[k]  = b;
    req_ad[k*W +: W] = a;
    req_bd[k*W +: W] = b;
`ifdef BINFUNC_ARB_OPSEL_EN
    exp_op[k] = op;
    req_op[k*2 +: 2] = op;
`else
    exp_op[k] = 2'd0;
    if (op != 2'd0) $display("note: op %0d ignored in AND-only build", op);
`endif
  endtask

  // Wait for the next ack, check it against the model, then release it
  task automatic serve(input logic [N-1:0] pend, output int won);
    int  exp_w;
    int  g;
    bit  seen;
    exp_w = ref_pick(pend, m_ptr);
    won   = -1;
    seen  = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (req_a != '0) begin
        seen = 1'b1;
        break;
      end
    end
    check("ack_seen", 32'(seen), 32'd1);
    if (!seen) return;
    g   = int'(grant_idx);
    won = g;
    check("ack_onehot", $countones(req_a), 1);
    check("grant_idx", g, exp_w);
    check("req_a_bit", 32'(req_a), 32'(1 << exp_w));
    check("res_d", res_d, ref_fn(exp_op[exp_w], exp_a[exp_w], exp_b[exp_w]));
    check("fu_r_in_ack", 32'(fu_r), 32'd0);
    req_r[g] = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (req_a == '0) begin
        seen = 1'b1;
        break;
      end
    end
    check("ack_release", 32'(seen), 32'd1);
    m_ptr = (exp_w + 1) % N;
  endtask

  // Function-unit model: acks after fu_delay cycles of fu_r, returns to zero after fu_r drops
  initial begin
    fu_a  = 1'b0;
    fu_od = '0;
    forever begin
      @(negedge clk);
      if (fu_r && !fu_a) begin
        fu_cnt++;
        if (fu_cnt >= fu_delay) begin
          fu_od  = ref_fn(w_fu_op, fu_ad, fu_bd);
          fu_a   = 1'b1;
          fu_cnt = 0;
        end
      end else if (!fu_r) begin
        fu_a   = 1'b0;
        fu_cnt = 0;
      end
    end
  end

  // Protocol invariants: one-hot-or-zero ack, never FU request alongside an ack
  always @(negedge clk) begin
    if (initialise_n && (($countones(req_a) > 1) || (fu_r && (req_a != '0)))) viol++;
  end

  initial begin
    int         won;
    int         pulses;
    logic [N-1:0] pend;
    logic [N-1:0] seen_bits;

    vecs[0] = '{idx: 0, a: 8'hF0, b: 8'h3C, res: 8'h30};
    vecs[1] = '{idx: 1, a: 8'hFF, b: 8'h0F, res: 8'h0F};
    vecs[2] = '{idx: 3, a: 8'hFF, b: 8'hFF, res: 8'hFF};
    vecs[3] = '{idx: 2, a: 8'hAA, b: 8'h5F, res: 8'h0A};

    initialise_n = 1'b0;
    req_r  = '0;
    req_ad = '0;
    req_bd = '0;
`ifdef BINFUNC_ARB_OPSEL_EN
    req_op = '0;
`endif
    for (int k = 0; k < N; k++) set_req(k, 8'h00, 8'h00, 2'd0);
    repeat (2) @(negedge clk);
    check("rst_req_a", 32'(req_a), 32'd0);
    check("rst_fu_r", 32'(fu_r), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_res_d", res_d, 32'd0);
    check("rst_fu_ad", fu_ad, 32'd0);
    check("rst_grant_idx", grant_idx, 32'd0);
    initialise_n = 1'b1;
    @(negedge clk);

    // Single-requester table vectors
    for (int v = 0; v < 4; v++) begin
      set_req(vecs[v].idx, vecs[v].a, vecs[v].b, 2'd0);
      req_r[vecs[v].idx] = 1'b1;
      @(negedge clk);
      check("fu_r_after_one_edge", 32'(fu_r), 32'd1);
      check("busy_in_issue", 32'(busy), 32'd1);
      serve(4'(1 << vecs[v].idx), won);
      check("vec_res_d", res_d, vecs[v].res);
      check("vec_grant", grant_idx, vecs[v].idx);
    end

    // Reset while the FU request is outstanding
    fu_delay = 7;
    set_req(1, 8'h77, 8'h0F, 2'd0);
    req_r = 4'b0010;
    repeat (2) @(negedge clk);
    check("pre_reset_fu_r", 32'(fu_r), 32'd1);
    initialise_n = 1'b0;
    #1;
    check("mid_rst_fu_r", 32'(fu_r), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_req_a", 32'(req_a), 32'd0);
    check("mid_rst_grant", grant_idx, 32'd0);
    check("mid_rst_res_d", res_d, 32'd0);
    req_r = '0;
    m_ptr = 0;
    @(negedge clk);
    initialise_n = 1'b1;
    @(negedge clk);

    // All four at once: rotation from a freshly reset pointer
    fu_delay = 1;
    set_req(0, 8'h12, 8'hF3, 2'd0);
    set_req(1, 8'h9C, 8'h5A, 2'd0);
    set_req(2, 8'hE7, 8'h7E, 2'd0);
    set_req(3, 8'h81, 8'hFF, 2'd0);
    req_r = 4'hF;
    pend  = 4'hF;
    for (int i = 0; i < N; i++) begin
      serve(pend, won);
      check("all4_order", won, i);
      if (won >= 0) pend[won] = 1'b0;
    end

    // Rotation after wrap: grant 3, then {0,3} must give 0 first
    set_req(3, 8'h3C, 8'hC3, 2'd0);
    req_r = 4'b1000;
    serve(4'b1000, won);
    set_req(0, 8'hF0, 8'h0F, 2'd0);
    req_r = 4'b1001;
    serve(4'b1001, won);
    check("wrap_first", won, 0);
    serve(4'b1000, won);
    check("wrap_second", won, 3);

    // Slow FU: request held, no ack, operands frozen even when inputs change
    fu_delay = 7;
    set_req(0, 8'hF0, 8'h3C, 2'd0);
    req_r = 4'b0001;
    @(negedge clk);
    for (int j = 0; j < 6; j++) begin
      check("slow_fu_r", 32'(fu_r), 32'd1);
      check("slow_req_a", 32'(req_a), 32'd0);
      check("slow_fu_ad", fu_ad, 32'hF0);
      check("slow_fu_bd", fu_bd, 32'h3C);
      req_ad[W-1:0] = 8'(j * 37 + 1);
      req_bd[W-1:0] = 8'(j * 11);
      @(negedge clk);
    end
    serve(4'b0001, won);
    check("slow_res_d", res_d, 32'h30);

    // Granted requester withdraws during ISSUE: one-cycle ack, then idle
    fu_delay = 3;
    set_req(2, 8'hCC, 8'hAA, 2'd0);
    req_r = 4'b0100;
    repeat (2) @(negedge clk);
    req_r = '0;
    pulses    = 0;
    seen_bits = '0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (req_a != '0) begin
        pulses++;
        seen_bits = req_a;
      end
    end
    check("viol_pulses", pulses, 1);
    check("viol_ack_bit", 32'(seen_bits), 32'h4);
    check("viol_res_d", res_d, 32'h88);
    check("viol_busy", 32'(busy), 32'd0);
    m_ptr = 3;

`ifdef BINFUNC_ARB_OPSEL_EN
    // Op select: XOR from requester 1
    fu_delay = 1;
    set_req(1, 8'hAA, 8'hFF, 2'd2);
    req_r = 4'b0010;
    @(negedge clk);
    check("opsel_fu_op", fu_op, 32'd2);
    serve(4'b0010, won);
    check("opsel_res_d", res_d, 32'h55);
`endif

    // Randomised rounds against the rotation model
    for (int r = 0; r < 40; r++) begin
      fu_delay = int'($urandom_range(1, 4));
      pend = 4'($urandom_range(1, 15));
      for (int k = 0; k < N; k++) begin
`ifdef BINFUNC_ARB_OPSEL_EN
        set_req(k, 8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)));
`else
        set_req(k, 8'($urandom), 8'($urandom), 2'd0);
`endif
      end
      req_r = pend;
      while (pend != '0) begin
        serve(pend, won);
        if (won < 0) begin
          req_r = '0;
          pend  = '0;
        end else begin
          pend[won] = 1'b0;
        end
      end
    end

    check("protocol_violations", viol, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
